// File: rtl/mux_scan_ctrl_pkg.sv
// Shared definitions for the 8:1 mux scan sequencer: channel count, select width
// and FSM state encodings.
package mux_scan_ctrl_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] LAST_CH = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Frame output bus of the mux scan sequencer: assembled frame plus valid/ready
// handshake. The sequencer is the master.
interface mux_scan_ctrl_if;
  import mux_scan_ctrl_pkg::*;

  logic [NUM_CH-1:0] frame;
  logic              frame_valid;
  logic              frame_ready;

  modport master (output frame, output frame_valid, input frame_ready);
  modport slave  (input frame, input frame_valid, output frame_ready);

endinterface

// File: rtl/mux_scan_ctrl_settle_timer.sv
// Settle-window counter: counts up while clr is low, flags done when the count
// reaches SETTLE_CYC-1.
module settle_timer #(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear or increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Upstream sequencer for the 8:1 mux: steps the select through channels 0..7 with a
// settle window on each, samples y, and presents the assembled frame via valid/ready.
module mux_scan_ctrl
  import mux_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont_en,
  input  logic             mux_y,
  input  logic             clr_ovr,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             overrun,
  mux_scan_ctrl_if.master  fbus
);

  state_e              state_d, state_q;
  logic [SEL_W-1:0]    sel_d, sel_q;
  logic [NUM_CH-2:0]   shadow_d, shadow_q;
  logic [NUM_CH-1:0]   frame_d, frame_q;
  logic                frame_valid_d, frame_valid_q;
  logic                overrun_d, overrun_q;
  logic                busy_d, busy_q;
  logic                tmr_clr;
  logic                tmr_done;
  logic                frame_done;
  logic                accept;
  logic                load;

  settle_timer #(
    .SETTLE_CYC (SETTLE_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .done (tmr_done)
  );

  // Scan FSM, shadow capture and output holding register next-state.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    overrun_d     = overrun_q;
    tmr_clr       = 1'b1;
    frame_done    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d = '0;
        if (start) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        tmr_clr = 1'b0;
        if (tmr_done) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (sel_q == LAST_CH) begin
          // Channel 7 goes straight into the frame; the shadow holds only 0..6.
          frame_done = 1'b1;
          sel_d      = '0;
          state_d    = cont_en ? ST_SETTLE : ST_IDLE;
        end else begin
          shadow_d[sel_q] = mux_y;
          sel_d           = sel_q + SEL_W'(1);
          state_d         = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase

    accept = frame_valid_q & fbus.frame_ready;
    load   = frame_done & (~frame_valid_q | accept);

    if (load) begin
      frame_d       = {mux_y, shadow_q};
      frame_valid_d = 1'b1;
    end else if (accept) begin
      frame_valid_d = 1'b0;
    end else begin
      frame_valid_d = frame_valid_q;
    end

    // A drop in the same cycle as a clear must still be reported.
    if (frame_done && !load) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign sel              = sel_q;
  assign busy             = busy_q;
  assign overrun          = overrun_q;
  assign fbus.frame       = frame_q;
  assign fbus.frame_valid = frame_valid_q;

endmodule
